add16_seq_ctrl: RTL and testbench
=================================

ADD16_SEQ_CTRL -- requirements
Module: add16_seq_ctrl

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: rst_n  input  1  reset, synchronous, active-low.
REQ-003 SHALL have port: in_valid  input  1  operand request valid.
REQ-004 SHALL have port: in_ready  output  1  block idle, can accept operands.
REQ-005 SHALL have port: a  input  16  operand A, two's complement.
REQ-006 SHALL have port: b  input  16  operand B, two's complement.
REQ-007 SHALL have port: sub  input  1  1 = compute A-B, 0 = compute A+B.
REQ-008 SHALL have port: out_valid  output  1  result available.
REQ-009 SHALL have port: out_ready  input  1  consumer takes result.
REQ-010 SHALL have port: result  output  16  sum/difference, registered.
REQ-011 SHALL have port: cout  output  1  carry out of bit 15, registered.
REQ-012 SHALL have port: ovfl  output  1  signed overflow flag, registered.

Function
REQ-013 SHALL compute the 16-bit result with exactly one adder_cla_4bit instance, reused once per nibble; no other adder.
REQ-014 SHALL implement states IDLE, RUN, DONE plus a 2-bit nibble counter cnt.
REQ-015 IDLE: in_ready=1, out_valid=0; on in_valid&&in_ready edge, latch a, b, sub; set carry reg = sub, cnt=0; go RUN.
REQ-016 RUN: adder inputs a[4*cnt+:4], (b^{16{sub}})[4*cnt+:4], cin=carry reg; in_ready=0, out_valid=0.
REQ-017 RUN, each edge: result nibble cnt <= adder s; carry reg <= adder cout; cnt++.
REQ-018 RUN with cnt=3: also capture cout from adder cout and ovfl from adder ovfl; go DONE.
REQ-019 Latency: out_valid SHALL rise exactly 4 rising edges after the accepting edge.
REQ-020 DONE: out_valid=1, in_ready=0; result, cout, ovfl stable until out_ready=1 edge, then go IDLE.
REQ-021 No bypass: a new request SHALL NOT be accepted in the same cycle a result is taken; in_ready rises the cycle after.
REQ-022 in_valid and operand changes during RUN/DONE SHALL be ignored.
REQ-023 result/cout/ovfl SHALL hold the last value in IDLE until overwritten by the next operation.
REQ-024 Wrap-around: unsigned carry out of bit 15 reported only on cout; in non-saturating build, result is modulo 2^16.

Reset
REQ-025 rst_n=0 at an edge SHALL force IDLE, cnt=0, carry reg=0, result=0x0000, cout=0, ovfl=0, out_valid=0.
REQ-026 Reset during RUN or DONE SHALL abandon the operation; in_ready=1 the cycle after release.

Configuration
REQ-027 Macro SAT_ARITH_EN defined: if ovfl=1 at capture, result SHALL be 0x7FFF when latched a[15]=0, 0x8000 when a[15]=1; ovfl still reported 1.
REQ-028 SAT_ARITH_EN undefined: result SHALL be the raw wrapped sum; ovfl still reported.

Verification
REQ-029 a=0x1234, b=0x0FFF, sub=0 -> result 0x2233, cout 0, ovfl 0, out_valid 4 edges after accept.
REQ-030 a=0x7FFF, b=0x0001, sub=0 -> ovfl 1; result 0x7FFF with SAT_ARITH_EN, 0x8000 without.
REQ-031 a=0x8000, b=0x0001, sub=1 -> ovfl 1; result 0x8000 with SAT_ARITH_EN, 0x7FFF without.
REQ-032 a=0xFFFF, b=0x0001, sub=0 -> result 0x0000, cout 1, ovfl 0 (carry ripples through all nibbles).
REQ-033 Hold out_ready=0 three cycles in DONE -> out_valid and result stable, in_ready 0; out_ready=1 -> IDLE next edge, in_ready 1.
REQ-034 Assert rst_n=0 during RUN with cnt=2 -> next cycle result 0x0000, out_valid 0, in_ready 1; a following 0x0001+0x0001 returns 0x0002.

Source files
------------

// File: rtl/add16_seq_ctrl_if.sv
// Operand/result bundle for the nibble-serial 16-bit add/sub controller.
// Latency: n/a (wiring only).
// Backpressure: valid/ready on both the operand side and the result side.
interface add16_seq_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] result;
  logic        cout;
  logic        ovfl;

  // Producer of operands / consumer of results.
  modport master (
    output in_valid, a, b, sub, out_ready,
    input  in_ready, out_valid, result, cout, ovfl
  );

  // The arithmetic block itself.
  modport slave (
    input  in_valid, a, b, sub, out_ready,
    output in_ready, out_valid, result, cout, ovfl
  );
endinterface

// File: rtl/add16_seq_ctrl.sv
// 16-bit add/sub computed one nibble per cycle through a single 4-bit CLA.
// Latency: out_valid rises 4 clk edges after the accepting edge.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE.
// Optional feature: define SAT_ARITH_EN to saturate the result on signed overflow.

// 4-bit carry-lookahead adder; ovfl is the signed overflow of this nibble,
// which for the top nibble equals the 16-bit signed overflow.
module adder_cla_4bit (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       cout,
  output logic       ovfl
);
  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  // Generate/propagate and flattened lookahead carries.
  always_comb begin
    g    = a & b;
    p    = a ^ b;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & cin);
    s    = p ^ c[3:0];
    cout = c[4];
    ovfl = c[4] ^ c[3];
  end
endmodule

module add16_seq_ctrl (
  input  logic               clk,
  input  logic               rst_n,
  add16_seq_ctrl_if.slave    bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state_q;
  state_t      state_d;
  logic [1:0]  cnt_q;
  logic        carry_q;
  logic [15:0] a_q;
  logic [15:0] b_q;      // B already conditioned for subtraction (inverted when sub)
  logic [15:0] result_q;
  logic        cout_q;
  logic        ovfl_q;

  logic [3:0]  nib_base;
  logic [3:0]  sum_nib;
  logic        c_nib;
  logic        ov_nib;
  logic        in_ready_c;
  logic        out_valid_c;

  assign nib_base = {cnt_q, 2'b00};

  adder_cla_4bit u_cla (
    .a    (a_q[nib_base +: 4]),
    .b    (b_q[nib_base +: 4]),
    .cin  (carry_q),
    .s    (sum_nib),
    .cout (c_nib),
    .ovfl (ov_nib)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state and handshake outputs; no bypass from DONE straight to accept.
  always_comb begin
    state_d     = state_q;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) state_d = RUN;
      end
      RUN: begin
        if (cnt_q == 2'd3) state_d = DONE;
      end
      DONE: begin
        out_valid_c = 1'b1;
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand capture and nibble-serial accumulation of result/flags.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q    <= 2'd0;
      carry_q  <= 1'b0;
      a_q      <= 16'h0000;
      b_q      <= 16'h0000;
      result_q <= 16'h0000;
      cout_q   <= 1'b0;
      ovfl_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.in_valid) begin
            a_q     <= bus.a;
            b_q     <= bus.b ^ {16{bus.sub}};
            carry_q <= bus.sub;   // +1 completes the two's complement of B
            cnt_q   <= 2'd0;
          end
        end
        RUN: begin
          result_q[nib_base +: 4] <= sum_nib;
          carry_q                 <= c_nib;
          cnt_q                   <= cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            cout_q <= c_nib;
            ovfl_q <= ov_nib;
`ifdef SAT_ARITH_EN
            // Overflow direction follows the sign of A.
            if (ov_nib) result_q <= a_q[15] ? 16'h8000 : 16'h7FFF;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.result    = result_q;
  assign bus.cout      = cout_q;
  assign bus.ovfl      = ovfl_q;
endmodule

// File: tb/tb_add16_seq_ctrl.sv
// Scoreboard bench for add16_seq_ctrl: randomized and directed add/sub requests.
// Latency: checks out_valid rises 4 edges after accept.
// Backpressure: random and forced out_ready; checks result stability while held.
module tb_add16_seq_ctrl;
  logic clk;
  logic rst_n;
  int   cyc;
  int   n_chk;
  int   n_fail;
  int   rdy_mode;   // 0 random, 1 force low, 2 force high

  typedef struct {
    logic [15:0] r;
    logic        c;
    logic        o;
    int          acc;
  } exp_t;

  exp_t sb[$];

  add16_seq_ctrl_if bus();

  add16_seq_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: plain signed/unsigned integer arithmetic.
  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic s);
    exp_t m;
    int sa;
    int sbv;
    int r;
    int ua;
    int ub;
    sa  = $signed(a);
    sbv = $signed(b);
    ua  = int'(a);
    ub  = int'(b);
    r   = s ? sa - sbv : sa + sbv;
    m.r = r[15:0];
    m.c = s ? (ua >= ub) : ((ua + ub) > 65535);
    m.o = (r > 32767) || (r < -32768);
`ifdef SAT_ARITH_EN
    if (m.o) m.r = (r > 0) ? 16'h7FFF : 16'h8000;
`endif
    m.acc = 0;
    return m;
  endfunction

  task automatic wait_ready();
    int n;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.in_ready) chk(1'b0, "in_ready_timeout", 32'd0, 32'd1);
  endtask

  // Issue one request; expected value comes from the model unless use_k is set.
  // Returns two edges after the accept edge (cnt is 2 inside the DUT).
  task automatic send(input logic [15:0] a, input logic [15:0] b, input logic s,
                      input bit use_k, input logic [15:0] kr, input logic kc, input logic ko);
    exp_t e;
    wait_ready();
    bus.in_valid = 1'b1;
    bus.a        = a;
    bus.b        = b;
    bus.sub      = s;
    @(posedge clk); #1;
    e = model(a, b, s);
    if (use_k) begin
      e.r = kr;
      e.c = kc;
      e.o = ko;
    end
    e.acc = cyc;
    sb.push_back(e);
    // Requests presented while busy must be ignored.
    for (int i = 0; i < 2; i++) begin
      bus.a   = 16'($urandom);
      bus.b   = 16'($urandom);
      bus.sub = 1'($urandom);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
  endtask

  // Consumer ready driver.
  initial begin
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (rdy_mode)
        1:       bus.out_ready = 1'b0;
        2:       bus.out_ready = 1'b1;
        default: bus.out_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Monitor: compares presented results against the scoreboard head.
  initial begin
    bit prev_ov;
    bit prev_hs;
    prev_ov = 1'b0;
    prev_hs = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_ov = 1'b0;
        prev_hs = 1'b0;
      end else begin
        if (prev_hs) begin
          chk(bus.in_ready === 1'b1, "in_ready_after_take", 32'(bus.in_ready), 32'd1);
          chk(bus.out_valid === 1'b0, "out_valid_after_take", 32'(bus.out_valid), 32'd0);
        end
        prev_hs = 1'b0;
        if (bus.out_valid === 1'b1) begin
          chk(bus.in_ready === 1'b0, "in_ready_in_done", 32'(bus.in_ready), 32'd0);
          if (sb.size() == 0) begin
            chk(1'b0, "unexpected_out_valid", 32'd1, 32'd0);
          end else begin
            if (!prev_ov)
              chk((cyc - sb[0].acc) == 4, "latency", 32'(cyc - sb[0].acc), 32'd4);
            chk(bus.result === sb[0].r, "result", 32'(bus.result), 32'(sb[0].r));
            chk(bus.cout === sb[0].c, "cout", 32'(bus.cout), 32'(sb[0].c));
            chk(bus.ovfl === sb[0].o, "ovfl", 32'(bus.ovfl), 32'(sb[0].o));
            if (bus.out_ready === 1'b1) begin
              void'(sb.pop_front());
              prev_hs = 1'b1;
            end
          end
          prev_ov = 1'b1;
        end else begin
          prev_ov = 1'b0;
        end
      end
    end
  end

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (sb.size() != 0) chk(1'b0, "drain_timeout", 32'(sb.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Main stimulus.
  initial begin
    int n;
    n_chk        = 0;
    n_fail       = 0;
    cyc          = 0;
    rdy_mode     = 2;
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.a        = 16'h0000;
    bus.b        = 16'h0000;
    bus.sub      = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    chk(bus.in_ready === 1'b1, "rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk(bus.out_valid === 1'b0, "rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk(bus.result === 16'h0000, "rst_result", 32'(bus.result), 32'd0);
    chk(bus.cout === 1'b0, "rst_cout", 32'(bus.cout), 32'd0);
    chk(bus.ovfl === 1'b0, "rst_ovfl", 32'(bus.ovfl), 32'd0);

    // Directed corner cases with hand-derived expectations.
    send(16'h1234, 16'h0FFF, 1'b0, 1'b1, 16'h2233, 1'b0, 1'b0);
    drain();
`ifdef SAT_ARITH_EN
    send(16'h7FFF, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b0, 1'b1);
    drain();
    send(16'h8000, 16'h0001, 1'b1, 1'b1, 16'h8000, 1'b1, 1'b1);
    drain();
`else
    send(16'h7FFF, 16'h0001, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1);
    drain();
    send(16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    drain();
`endif
    send(16'hFFFF, 16'h0001, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
    drain();

    // Held result: out_ready low for several cycles in DONE, then released.
    rdy_mode = 1;
    send(16'hABCD, 16'h1357, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0);
    n = 0;
    while (!bus.out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk(bus.out_valid === 1'b1, "hold_reach_done", 32'(bus.out_valid), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    chk(bus.out_valid === 1'b1, "hold_out_valid", 32'(bus.out_valid), 32'd1);
    chk(bus.in_ready === 1'b0, "hold_in_ready", 32'(bus.in_ready), 32'd0);
    rdy_mode = 2;
    drain();

    // Randomized traffic with random consumer backpressure.
    rdy_mode = 0;
    for (int i = 0; i < 150; i++) begin
      send(16'($urandom), 16'($urandom), 1'($urandom), 1'b0, 16'h0000, 1'b0, 1'b0);
    end
    drain();

    // Reset in the middle of an operation (cnt == 2).
    rdy_mode = 2;
    send(16'h5555, 16'h3333, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    sb.delete();
    chk(bus.result === 16'h0000, "midrst_result", 32'(bus.result), 32'd0);
    chk(bus.out_valid === 1'b0, "midrst_out_valid", 32'(bus.out_valid), 32'd0);
    chk(bus.in_ready === 1'b1, "midrst_in_ready", 32'(bus.in_ready), 32'd1);
    send(16'h0001, 16'h0001, 1'b0, 1'b1, 16'h0002, 1'b0, 1'b0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
